// File: rtl/shifter_pkg.sv
// Shared mode encodings and elaboration-time helpers for the pipelined shifter.
// The sticky datapath is enabled by the SHIFT_STICKY_EN macro in the files that import this package.
package shifter_pkg;

  localparam logic [1:0] MODE_LSL = 2'b00;
  localparam logic [1:0] MODE_LSR = 2'b01;
  localparam logic [1:0] MODE_ASR = 2'b10;
  localparam logic [1:0] MODE_ROR = 2'b11;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (longint unsigned v = 1; v < 64'(n); v = v << 1) r++;
    return r;
  endfunction

  // Mux levels handled by each register stage.
  function automatic int unsigned levels_per_stage(input int unsigned levels,
                                                   input int unsigned stages);
    return (levels + stages - 1) / stages;
  endfunction

endpackage

// File: rtl/shift_align_stage.sv
// One registered slice of the shifter: applies mux levels LO..HI-1, then registers the result.
// Sticky accumulation exists only when SHIFT_STICKY_EN is defined.
module shift_align_stage
  import shifter_pkg::*;
#(
  parameter int unsigned SW = 32,
  parameter int unsigned L  = 5,
  parameter int unsigned LO = 0,
  parameter int unsigned HI = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush_i,
  input  logic          load_i,
  input  logic          valid_i,
  input  logic [1:0]    mode_i,
  input  logic [L-1:0]  shamt_i,
  input  logic [SW-1:0] data_i,
  input  logic          sticky_i,
  output logic          valid_o,
  output logic [1:0]    mode_o,
  output logic [L-1:0]  shamt_o,
  output logic [SW-1:0] data_o,
  output logic          sticky_o
);

  logic          valid_q, valid_d;
  logic [1:0]    mode_q, mode_d;
  logic [L-1:0]  shamt_q, shamt_d;
  logic [SW-1:0] data_q, data_d;
  logic [SW-1:0] lvl_data_c;
`ifdef SHIFT_STICKY_EN
  logic          sticky_q, sticky_d;
  logic          lvl_sticky_c;
`endif

  // Mux levels owned by this slice; level j moves data by 2^j.
  always_comb begin
    lvl_data_c = data_i;
`ifdef SHIFT_STICKY_EN
    lvl_sticky_c = sticky_i;
`endif
    for (int j = 0; j < int'(L); j++) begin
      if (j >= int'(LO) && j < int'(HI) && shamt_i[j]) begin
        case (mode_i)
          MODE_LSL: lvl_data_c = lvl_data_c << (1 << j);
          MODE_LSR: begin
`ifdef SHIFT_STICKY_EN
            lvl_sticky_c = lvl_sticky_c | (|(lvl_data_c & ~({SW{1'b1}} << (1 << j))));
`endif
            lvl_data_c = lvl_data_c >> (1 << j);
          end
          MODE_ASR: begin
`ifdef SHIFT_STICKY_EN
            lvl_sticky_c = lvl_sticky_c | (|(lvl_data_c & ~({SW{1'b1}} << (1 << j))));
`endif
            lvl_data_c = SW'($signed(lvl_data_c) >>> (1 << j));
          end
          default: lvl_data_c = (lvl_data_c >> (1 << j)) | (lvl_data_c << (SW - (1 << j)));
        endcase
      end
    end
  end

  always_comb begin
    valid_d = valid_q;
    mode_d  = mode_q;
    shamt_d = shamt_q;
    data_d  = data_q;
`ifdef SHIFT_STICKY_EN
    sticky_d = sticky_q;
`endif
    if (load_i) begin
      valid_d = valid_i;
      mode_d  = mode_i;
      shamt_d = shamt_i;
      data_d  = lvl_data_c;
`ifdef SHIFT_STICKY_EN
      sticky_d = lvl_sticky_c;
`endif
    end
    if (flush_i) valid_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      mode_q  <= '0;
      shamt_q <= '0;
      data_q  <= '0;
`ifdef SHIFT_STICKY_EN
      sticky_q <= 1'b0;
`endif
    end else begin
      valid_q <= valid_d;
      mode_q  <= mode_d;
      shamt_q <= shamt_d;
      data_q  <= data_d;
`ifdef SHIFT_STICKY_EN
      sticky_q <= sticky_d;
`endif
    end
  end

  assign valid_o = valid_q;
  assign mode_o  = mode_q;
  assign shamt_o = shamt_q;
  assign data_o  = data_q;
`ifdef SHIFT_STICKY_EN
  assign sticky_o = sticky_q;
`else
  logic sticky_unused;
  assign sticky_unused = sticky_i;
  assign sticky_o      = 1'b0;
`endif

endmodule

// File: rtl/shift_align_pipe.sv
// Pipelined LSL/LSR/ASR/ROR shifter with valid/ready flow control and optional sticky output.
// Define SHIFT_STICKY_EN to build the sticky (OR of bits dropped off the LSB) datapath.
module shift_align_pipe
  import shifter_pkg::*;
#(
  parameter int unsigned SW     = 32,
  parameter int unsigned EW     = 6,
  parameter int unsigned STAGES = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush_i,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  input  logic [1:0]    mode_i,
  input  logic [EW-1:0] shamt_i,
  input  logic [SW-1:0] data_i,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic [SW-1:0] data_o,
  output logic          sticky_o
);

  localparam int unsigned L  = clog2(SW);
  localparam int unsigned P  = levels_per_stage(L, STAGES);
  localparam int unsigned RW = EW + 1;

  logic          valid_w  [STAGES+1];
  logic          load_c   [STAGES+1];
  logic [1:0]    mode_w   [STAGES+1];
  logic [L-1:0]  shamt_w  [STAGES+1];
  logic [SW-1:0] data_w   [STAGES+1];
  logic          sticky_w [STAGES+1];

  logic [RW-1:0] rem_c;
  logic          sat_c;
  logic [L-1:0]  pre_shamt_c;
  logic [SW-1:0] pre_data_c;
  logic          pre_sticky_c;

  // Stage-0 pre-decode: ROR amount reduced mod SW by restoring subtraction, saturation resolved here.
  always_comb begin
    rem_c = {1'b0, shamt_i};
    for (int i = int'(EW); i >= 0; i--) begin
      if ((64'(SW) << i) <= 64'(rem_c)) rem_c = rem_c - RW'(64'(SW) << i);
    end
    sat_c        = (mode_i != MODE_ROR) && ({1'b0, shamt_i} >= RW'(SW));
    pre_data_c   = data_i;
    pre_shamt_c  = (mode_i == MODE_ROR) ? rem_c[L-1:0] : shamt_i[L-1:0];
    pre_sticky_c = 1'b0;
    if (sat_c) begin
      pre_data_c  = (mode_i == MODE_ASR && data_i[SW-1]) ? '1 : '0;
      pre_shamt_c = '0;
`ifdef SHIFT_STICKY_EN
      pre_sticky_c = (mode_i == MODE_LSR || mode_i == MODE_ASR) && (|data_i);
`endif
    end
  end

  assign valid_w[0]  = in_valid_i;
  assign mode_w[0]   = mode_i;
  assign shamt_w[0]  = pre_shamt_c;
  assign data_w[0]   = pre_data_c;
  assign sticky_w[0] = pre_sticky_c;

  // A stage loads when empty or when its successor loads; the last stage follows out_ready_i.
  always_comb begin
    for (int k = 0; k <= int'(STAGES); k++) load_c[k] = 1'b0;
    load_c[STAGES] = out_ready_i;
    for (int k = int'(STAGES) - 1; k >= 0; k--) begin
      load_c[k] = !valid_w[k+1] || load_c[k+1];
    end
  end

  for (genvar s = 0; s < int'(STAGES); s++) begin : g_stage
    localparam int unsigned LO = s * P;
    localparam int unsigned HI = ((s + 1) * P < L) ? (s + 1) * P : L;
    shift_align_stage #(
      .SW (SW),
      .L  (L),
      .LO (LO),
      .HI (HI)
    ) u_stage (
      .clk      (clk),
      .rst      (rst),
      .flush_i  (flush_i),
      .load_i   (load_c[s]),
      .valid_i  (valid_w[s]),
      .mode_i   (mode_w[s]),
      .shamt_i  (shamt_w[s]),
      .data_i   (data_w[s]),
      .sticky_i (sticky_w[s]),
      .valid_o  (valid_w[s+1]),
      .mode_o   (mode_w[s+1]),
      .shamt_o  (shamt_w[s+1]),
      .data_o   (data_w[s+1]),
      .sticky_o (sticky_w[s+1])
    );
  end

  assign in_ready_o  = load_c[0];
  assign out_valid_o = valid_w[STAGES];
  assign data_o      = data_w[STAGES];
  assign sticky_o    = sticky_w[STAGES];

  logic tail_unused;
  assign tail_unused = ^{mode_w[STAGES], shamt_w[STAGES], rem_c[RW-1:L]};

endmodule

// File: tb/tb_shift_align_pipe.sv
// Self-checking bench for shift_align_pipe: directed scenarios plus randomized traffic against a behavioural model.
module tb_shift_align_pipe;

  localparam int unsigned SW = 32;
  localparam int unsigned EW = 6;
  localparam int unsigned STAGES = 2;
`ifdef SHIFT_STICKY_EN
  localparam logic STK = 1'b1;
`else
  localparam logic STK = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          flush_i;
  logic          in_valid_i;
  logic          in_ready_o;
  logic [1:0]    mode_i;
  logic [EW-1:0] shamt_i;
  logic [SW-1:0] data_i;
  logic          out_valid_o;
  logic          out_ready_i;
  logic [SW-1:0] data_o;
  logic          sticky_o;

  int checks = 0;
  int fails  = 0;
  logic [32:0] exp_q[$];
  logic        stall_prev = 1'b0;
  logic [32:0] held;

  always #5 clk = ~clk;

  shift_align_pipe #(.SW(SW), .EW(EW), .STAGES(STAGES)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (flush_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .mode_i      (mode_i),
    .shamt_i     (shamt_i),
    .data_i      (data_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .data_o      (data_o),
    .sticky_o    (sticky_o)
  );

  // Behavioural reference: {sticky, result} straight from the shift definitions.
  function automatic logic [32:0] ref_shift(input logic [1:0] m, input int unsigned sh,
                                            input logic [31:0] d);
    logic [63:0] w;
    logic [31:0] r;
    logic        s;
    s = 1'b0;
    r = '0;
    case (m)
      2'b00: r = (sh >= 32) ? 32'd0 : d << sh;
      2'b01: begin
        if (sh >= 32) begin r = 32'd0; s = |d; end
        else begin r = d >> sh; s = (sh == 0) ? 1'b0 : |(d << (32 - sh)); end
      end
      2'b10: begin
        if (sh >= 32) begin r = d[31] ? 32'hFFFF_FFFF : 32'd0; s = |d; end
        else begin r = 32'($signed(d) >>> sh); s = (sh == 0) ? 1'b0 : |(d << (32 - sh)); end
      end
      default: begin
        w = {d, d} >> (sh % 32);
        r = w[31:0];
      end
    endcase
    return {s & STK, r};
  endfunction

  task automatic chk(input string tag, input logic [32:0] obs, input logic [32:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle, entered and left at a falling edge.
  task automatic cyc(input logic iv, input logic [1:0] m, input logic [EW-1:0] sh,
                     input logic [31:0] d, input logic ordy, input logic fl);
    int n;
    logic [32:0] e;
    in_valid_i  = iv;
    mode_i      = m;
    shamt_i     = sh;
    data_i      = d;
    out_ready_i = ordy;
    flush_i     = fl;
    #1;
    n = exp_q.size();
    chk("in_ready", {32'd0, in_ready_o}, {32'd0, (n < int'(STAGES)) || ordy});
    if (stall_prev) chk("stall_hold", {sticky_o, data_o}, held);
    if (out_valid_o && out_ready_i) begin
      if (exp_q.size() == 0) chk("spurious_out", 33'd1, 33'd0);
      else begin
        e = exp_q.pop_front();
        chk("result", {sticky_o, data_o}, e);
      end
    end
    if (fl) exp_q.delete();
    else if (iv && in_ready_o) exp_q.push_back(ref_shift(m, int'(sh), d));
    stall_prev = out_valid_o && !out_ready_i && !fl;
    held = {sticky_o, data_o};
    @(negedge clk);
  endtask

  // Issue into an empty pipe and confirm the result lands exactly STAGES cycles later.
  task automatic issue_lat(input logic [1:0] m, input logic [EW-1:0] sh, input logic [31:0] d,
                           input logic [32:0] want);
    cyc(1'b1, m, sh, d, 1'b1, 1'b0);
    chk("lat_early", {32'd0, out_valid_o}, 33'd0);
    cyc(1'b0, 2'b00, '0, '0, 1'b1, 1'b0);
    chk("lat_valid", {32'd0, out_valid_o}, 33'd1);
    chk("directed", {sticky_o, data_o}, want);
    cyc(1'b0, 2'b00, '0, '0, 1'b1, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 2'b00, '0, '0, 1'b1, 1'b0);
  endtask

  initial begin
    logic [EW-1:0] sh;
    rst = 1'b1; flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b0;
    mode_i = 2'b00; shamt_i = '0; data_i = '0;
    @(negedge clk);
    chk("reset_valid", {32'd0, out_valid_o}, 33'd0);
    chk("reset_data", {sticky_o, data_o}, 33'd0);
    rst = 1'b0;

    issue_lat(2'b01, 6'd4,  32'h8000_000F, {STK, 32'h0800_0000});
    issue_lat(2'b10, 6'd40, 32'h8000_0001, {STK, 32'hFFFF_FFFF});
    issue_lat(2'b00, 6'd40, 32'h8000_0001, {1'b0, 32'h0000_0000});
    issue_lat(2'b11, 6'd36, 32'h0000_0001, {1'b0, 32'h1000_0000});
    issue_lat(2'b01, 6'd0,  32'hDEAD_BEEF, {1'b0, 32'hDEAD_BEEF});
    issue_lat(2'b10, 6'd31, 32'h4000_0001, {STK, 32'h0000_0000});

    // Back-to-back at full rate, then a 5-cycle output stall and release.
    for (int i = 0; i < 8; i++) cyc(1'b1, 2'($urandom), 6'($urandom), $urandom, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) cyc(1'b1, 2'($urandom), 6'($urandom), $urandom, 1'b0, 1'b0);
    chk("stall_depth", 33'(exp_q.size()), 33'(STAGES));
    idle(4);
    chk("stall_drain", 33'(exp_q.size()), 33'd0);

    // Flush with two items in flight and a simultaneous input.
    cyc(1'b1, 2'b01, 6'd3, 32'h1234_5678, 1'b0, 1'b0);
    cyc(1'b1, 2'b00, 6'd5, 32'h0F0F_0F0F, 1'b0, 1'b0);
    cyc(1'b1, 2'b10, 6'd7, 32'hFFFF_0000, 1'b0, 1'b1);
    chk("flush_valid", {32'd0, out_valid_o}, 33'd0);
    issue_lat(2'b01, 6'd8, 32'hABCD_00FF, {STK, 32'h00AB_CD00});

    // Asynchronous reset mid-stream.
    cyc(1'b1, 2'b11, 6'd9, 32'h1357_9BDF, 1'b0, 1'b0);
    cyc(1'b1, 2'b10, 6'd2, 32'h8000_0003, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("rst_valid", {32'd0, out_valid_o}, 33'd0);
    chk("rst_data", {sticky_o, data_o}, 33'd0);
    exp_q.delete();
    stall_prev = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    issue_lat(2'b01, 6'd4, 32'h8000_000F, {STK, 32'h0800_0000});

    // Randomized traffic with backpressure and occasional flushes.
    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(0, 7))
        0:       sh = '0;
        1:       sh = 6'd31;
        2:       sh = 6'd32;
        default: sh = 6'($urandom_range(0, 63));
      endcase
      cyc($urandom_range(0, 3) != 0, 2'($urandom), sh, $urandom,
          $urandom_range(0, 9) < 7, $urandom_range(0, 49) == 0);
    end
    idle(4);
    chk("final_drain", 33'(exp_q.size()), 33'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
